// File: rtl/mul_share_arbiter_pkg.sv
// Shared constants and sizing helpers for the shared-multiplier arbiter family.
package mul_share_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Wait counter only has to reach TIMEOUT-1.
    function automatic int cnt_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int prod_width(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/mul_share_arbiter_rr_picker.sv
// Combinational round-robin select: lowest request above last_grant, else lowest overall.
module mul_share_arbiter_rr_picker
    import mul_share_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N_REQ-1:0] winner_oh,
    output logic [IDX_W-1:0] winner_idx,
    output logic             any_req
);

    logic [IDX_W:0]     shift_s;
    logic [N_REQ-1:0]   upper_s;
    logic [N_REQ-1:0]   pool_s;

    // Mask off everything at or below last_grant; fall back to the full vector on wrap.
    always_comb begin
        shift_s    = {1'b0, last_grant} + {{IDX_W{1'b0}}, 1'b1};
        upper_s    = req & ({N_REQ{1'b1}} << shift_s);
        pool_s     = (|upper_s) ? upper_s : req;
        winner_oh  = pool_s & (~pool_s + {{(N_REQ-1){1'b0}}, 1'b1});
        winner_idx = {IDX_W{1'b0}};
        for (int i = N_REQ - 1; i >= 0; i--) begin
            winner_idx = pool_s[i] ? IDX_W'(i) : winner_idx;
        end
        any_req    = |req;
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin front end that time-shares one sequential multiplier between N_REQ clients.
module mul_share_arbiter
    import mul_share_arbiter_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 2 * WIDTH + 8
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [N_REQ-1:0]               req,
    input  logic [N_REQ*WIDTH-1:0]         a_in,
    input  logic [N_REQ*WIDTH-1:0]         b_in,
    output logic [N_REQ-1:0]               gnt,
    output logic [N_REQ-1:0]               rsp_valid,
    output logic [prod_width(WIDTH)-1:0]   rsp_data,
    output logic                           rsp_err,
    output logic                           mul_start,
    output logic [WIDTH-1:0]               mul_a,
    output logic [WIDTH-1:0]               mul_b,
    input  logic                           mul_done,
    input  logic [prod_width(WIDTH)-1:0]   mul_product
);

    localparam int IDX_W = idx_width(N_REQ);
    localparam int CNT_W = cnt_width(TIMEOUT);

    logic [1:0]        state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [IDX_W-1:0]  idx_r;
    logic [IDX_W-1:0]  last_grant_r;
    logic [N_REQ-1:0]  sel_oh_r;
    logic [N_REQ-1:0]  win_oh_s;
    logic [IDX_W-1:0]  win_idx_s;
    logic              any_s;

    mul_share_arbiter_rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req        (req),
        .last_grant (last_grant_r),
        .winner_oh  (win_oh_s),
        .winner_idx (win_idx_s),
        .any_req    (any_s)
    );

    // Arbitration FSM; gnt, mul_start and rsp_valid are single-cycle pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            idx_r        <= '0;
            last_grant_r <= IDX_W'(N_REQ - 1);
            sel_oh_r     <= '0;
            gnt          <= '0;
            rsp_valid    <= '0;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
            mul_start    <= 1'b0;
            mul_a        <= '0;
            mul_b        <= '0;
        end else begin
            gnt       <= '0;
            rsp_valid <= '0;
            mul_start <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (any_s) begin
                        idx_r     <= win_idx_s;
                        sel_oh_r  <= win_oh_s;
                        mul_a     <= a_in[int'(win_idx_s) * WIDTH +: WIDTH];
                        mul_b     <= b_in[int'(win_idx_s) * WIDTH +: WIDTH];
                        gnt       <= win_oh_s;
                        mul_start <= 1'b1;
                        state_r   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt_r   <= '0;
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A done arriving on the final watchdog cycle still counts as success.
                    if (mul_done) begin
                        rsp_data  <= mul_product;
                        rsp_err   <= 1'b0;
                        rsp_valid <= sel_oh_r;
                        state_r   <= ST_RESP;
                    end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= sel_oh_r;
                        state_r   <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_RESP: begin
                    last_grant_r <= idx_r;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
